// File: rtl/addsub_rr_scheduler_pkg.sv
// Shared definitions for the add/sub round-robin scheduler.
//   - op encodings (add/subtract)
//   - FSM state type (IDLE, EXEC, HOLD)
//   - default operand width and requester-id width helper
package addsub_rr_scheduler_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Requester id width: at least one bit even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_rr_scheduler_if.sv
// Request/response bundle for the add/sub scheduler.
//   req_valid/req_ready/req_op : per-requester handshake and op (0 add, 1 sub)
//   req_a/req_b                : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready        : single response handshake
//   rsp_id/rsp_result          : owning requester and wrapped result
//   rsp_ovp/rsp_ovn            : positive / negative overflow flags
// Modports: master = requester/consumer side, slave = scheduler side.
interface addsub_rr_scheduler_if
    import addsub_rr_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REQ = 2
);
    localparam int IDW = id_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_ovp;
    logic                   rsp_ovn;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovp, rsp_ovn
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovp, rsp_ovn
    );

endinterface

// File: rtl/addsub_rr_scheduler_core.sv
// Combinational signed add/subtract with overflow detection.
//   a, b   : WIDTH-bit two's complement operands
//   op     : 0 = a+b, 1 = a-b
//   result : wrapped result (mod 2^WIDTH)
//   ovp    : true result above the largest representable value
//   ovn    : true result below the smallest representable value
module addsub_core
    import addsub_rr_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] result,
    output logic             ovp,
    output logic             ovn
);

    logic sa, sb, sr;

    always_comb begin
        result = (op == OP_SUB) ? (a - b) : (a + b);
        sa     = a[WIDTH-1];
        sb     = b[WIDTH-1];
        sr     = result[WIDTH-1];
        if (op == OP_SUB) begin
            ovp = ~sa &  sb &  sr;
            ovn =  sa & ~sb & ~sr;
        end else begin
            ovp = ~sa & ~sb &  sr;
            ovn =  sa &  sb & ~sr;
        end
    end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one signed add/sub datapath among N_REQ
// requesters.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : request/response bundle (slave side)
//   busy       : high whenever an op is in flight or a response is held
// One op per 2 cycles peak: accept -> EXEC -> HOLD, with a new accept
// allowed on the edge that retires the held response.
module addsub_rr_scheduler
    import addsub_rr_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addsub_rr_scheduler_if.slave  bus,
    output logic                  busy
);

    localparam int IDW = id_width(N_REQ);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    int unsigned      cand;
    logic             accept_win;
    logic             accept;
    logic [IDW-1:0]   ptr_nxt;

    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDW-1:0]   id_q;

    logic [WIDTH-1:0] core_result;
    logic             core_ovp, core_ovn;

    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_ovp_q, rsp_ovn_q;

    assign accept_win = (state == ST_IDLE) || (state == ST_HOLD && bus.rsp_ready);

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // rst_n gates ready so nothing is offered while reset is held.
    assign accept = rst_n && accept_win && gnt_found;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        int unsigned p;
        p       = (int'(gnt_idx) + 1) % N_REQ;
        ptr_nxt = p[IDW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_HOLD;
            ST_HOLD: if (bus.rsp_ready) state_nxt = accept ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
        end else if (accept) begin
            rr_ptr <= ptr_nxt;
            op_q   <= bus.req_op[gnt_idx];
            a_q    <= bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            b_q    <= bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            id_q   <= gnt_idx;
        end
    end

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .ovp    (core_ovp),
        .ovn    (core_ovn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ovp_q    <= 1'b0;
            rsp_ovn_q    <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_id_q     <= id_q;
            rsp_result_q <= core_result;
            rsp_ovp_q    <= core_ovp;
            rsp_ovn_q    <= core_ovn;
        end
    end

    // The response is valid exactly while HOLD, so reset drops it at once.
    assign bus.rsp_valid  = (state == ST_HOLD);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_ovp    = rsp_ovp_q;
    assign bus.rsp_ovn    = rsp_ovn_q;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
module tb_addsub_rr_scheduler;

    localparam int WIDTH = 16;
    localparam int N_REQ = 2;

    logic clk;
    logic rst_n;
    logic busy;
    int   total;
    int   bad;

    addsub_rr_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    addsub_rr_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic op, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[idx]         = 1'b1;
        bus.req_op[idx]            = op;
        bus.req_a[idx*WIDTH +: WIDTH] = a;
        bus.req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", bus.req_ready); end
        step();
        step();
        total++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_state rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, busy);
        end
        total++;
        if (bus.rsp_result !== 16'h0 || bus.rsp_id !== 1'b0 || bus.rsp_ovp !== 1'b0 || bus.rsp_ovn !== 1'b0) begin
            bad++; $display("FAIL reset_rsp id=%b res=%h ovp=%b ovn=%b want zeros", bus.rsp_id, bus.rsp_result, bus.rsp_ovp, bus.rsp_ovn);
        end
        bus.req_valid = '0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        set_req(0, 1'b0, 16'd1000, 16'd2000);
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b want=01", bus.req_ready); end
        step();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL add_exec rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, busy);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 16'd3000 ||
            bus.rsp_ovp !== 1'b0 || bus.rsp_ovn !== 1'b0) begin
            bad++; $display("FAIL add_rsp v=%b id=%b res=%0d ovp=%b ovn=%b want 1 0 3000 0 0",
                            bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL add_retire rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, busy);
        end
    endtask

    task automatic test_overflow();
        // -32000 - 4000 = -36000 wraps to 29536
        set_req(0, 1'b1, 16'(-32000), 16'd4000);
        step();
        bus.req_valid = '0;
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 16'd29536 ||
            bus.rsp_ovp !== 1'b0 || bus.rsp_ovn !== 1'b1) begin
            bad++; $display("FAIL ovn_sub v=%b id=%b res=%0d ovp=%b ovn=%b want 1 0 29536 0 1",
                            bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn);
        end
        step();
        // 32000 - (-4000) = 36000 wraps to -29536
        set_req(1, 1'b1, 16'd32000, 16'(-4000));
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL ovp_ready got=%b want=10", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 16'(-29536) ||
            bus.rsp_ovp !== 1'b1 || bus.rsp_ovn !== 1'b0) begin
            bad++; $display("FAIL ovp_sub v=%b id=%b res=%0d ovp=%b ovn=%b want 1 1 -29536 1 0",
                            bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn);
        end
        step();
        set_req(1, 1'b0, 16'd32000, 16'd4000);
        step();
        bus.req_valid = '0;
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 16'(-29536) ||
            bus.rsp_ovp !== 1'b1 || bus.rsp_ovn !== 1'b0) begin
            bad++; $display("FAIL ovp_add v=%b id=%b res=%0d ovp=%b ovn=%b want 1 1 -29536 1 0",
                            bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn);
        end
        step();
    endtask

    task automatic test_fairness();
        logic [15:0] exp_res;
        logic        exp_id;
        set_req(0, 1'b0, 16'd1, 16'd2);
        set_req(1, 1'b1, 16'd4000, 16'd32000);
        for (int i = 0; i < 4; i++) begin
            exp_id  = 1'(i % 2);
            exp_res = (i % 2 == 0) ? 16'd3 : 16'(-28000);
            step();
            total++;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL fair_exec%0d rsp_valid=%b busy=%b want 0 1", i, bus.rsp_valid, busy);
            end
            step();
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.rsp_result !== exp_res ||
                bus.rsp_ovp !== 1'b0 || bus.rsp_ovn !== 1'b0) begin
                bad++; $display("FAIL fair_rsp%0d v=%b id=%b res=%0d ovp=%b ovn=%b want 1 %b %0d 0 0", i,
                                bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn,
                                exp_id, $signed(exp_res));
            end
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b0, 16'd10, 16'd20);
        step();
        set_req(0, 1'b0, 16'd100, 16'(-200));
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 16'd30 ||
                bus.req_ready !== 2'b00 || busy !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d v=%b id=%b res=%0d rdy=%b busy=%b want 1 0 30 00 1", i,
                                bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.req_ready, busy);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready got=%b want=01", bus.req_ready); end
        step();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL bp_reaccept rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, busy);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 16'(-100) ||
            bus.rsp_ovp !== 1'b0 || bus.rsp_ovn !== 1'b0) begin
            bad++; $display("FAIL bp_rsp2 v=%b id=%b res=%0d ovp=%b ovn=%b want 1 0 -100 0 0",
                            bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn);
        end
        step();
    endtask

    task automatic test_mid_reset();
        // pointer now sits at 1, so req1 is the only one offered here
        set_req(1, 1'b0, 16'd5, 16'd5);
        step();
        bus.req_valid = '0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mr_exec busy=%b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mr_async rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, busy);
        end
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL mr_quiet%0d rsp_valid=%b busy=%b want 0 0", i, bus.rsp_valid, busy);
            end
        end
        set_req(0, 1'b1, 16'd7, 16'd9);
        set_req(1, 1'b0, 16'd1, 16'd1);
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mr_prio got=%b want=01", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 16'(-2) ||
            bus.rsp_ovp !== 1'b0 || bus.rsp_ovn !== 1'b0) begin
            bad++; $display("FAIL mr_rsp v=%b id=%b res=%0d ovp=%b ovn=%b want 1 0 -2 0 0",
                            bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_result), bus.rsp_ovp, bus.rsp_ovn);
        end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
